// File: rtl/sccpu_run_ctrl.sv
// Run-control sequencer: gates the single-cycle core's update enable (halt/run/step/breakpoint)
// and counts retired instructions. Define SCCPU_RUN_CTRL_BP_EN to build in the PC breakpoint.
module sccpu_run_ctrl #(
    parameter int STEP_W    = 16,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic        halted,
    output logic        bp_hit,
    output logic [31:0] ret_cnt,
    output logic [1:0]  state
);
    localparam logic [1:0] ST_HALT   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;
    localparam logic [1:0] ST_RESET  = RESET_RUN ? ST_RUN : ST_HALT;
    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_left_q, step_left_d;
    logic              bp_skip_q, bp_skip_d;
    logic              halted_q;
    logic [31:0]       ret_cnt_q;
    logic              bp_match, bp_hit_set, bp_hit_clr;
    logic              cmd_halt, cmd_run, cmd_step, cmd_set_bp;
    logic [STEP_W-1:0] step_count;

    // No ready: a command is consumed on every edge where cmd_valid is high.
    assign cmd_halt   = cmd_valid && (cmd_op == OP_HALT);
    assign cmd_run    = cmd_valid && (cmd_op == OP_RUN);
    assign cmd_step   = cmd_valid && (cmd_op == OP_STEP);
    assign cmd_set_bp = cmd_valid && (cmd_op == OP_SET_BP);
    assign step_count = (cmd_data[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_data[STEP_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_left_d = step_left_q;
        bp_skip_d   = bp_skip_q;
        bp_hit_set  = 1'b0;
        bp_hit_clr  = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (cmd_run) begin
                    state_d    = ST_RUN;
                    bp_skip_d  = 1'b1;
                    bp_hit_clr = 1'b1;
                end else if (cmd_step) begin
                    state_d     = ST_STEP;
                    step_left_d = step_count;
                    bp_hit_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                bp_skip_d = 1'b0;
                if (bp_match) begin
                    state_d    = ST_HALT;
                    bp_hit_set = 1'b1;
                end else if (cmd_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (cmd_halt) begin
                    state_d = ST_HALT;
                end else begin
                    step_left_d = step_left_q - 1'b1;
                    if (step_left_q <= STEP_W'(1)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Zero-latency breakpoint: the matching instruction is suppressed in its own cycle.
    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            ST_RUN:  cpu_en = !bp_match;
            ST_STEP: cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_left_q <= '0;
            bp_skip_q   <= 1'b0;
            halted_q    <= RESET_RUN ? 1'b0 : 1'b1;
            ret_cnt_q   <= '0;
        end else begin
            step_left_q <= step_left_d;
            bp_skip_q   <= bp_skip_d;
            halted_q    <= (state_d == ST_HALT);
            ret_cnt_q   <= ret_cnt_q + {31'd0, cpu_en};
        end
    end

`ifdef SCCPU_RUN_CTRL_BP_EN
    logic [31:0] bp_addr_q;
    logic        bp_valid_q;
    logic        bp_hit_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bp_addr_q  <= '0;
            bp_valid_q <= 1'b0;
            bp_hit_q   <= 1'b0;
        end else begin
            if (cmd_set_bp) begin
                bp_addr_q  <= {cmd_data[31:2], 2'b00};
                bp_valid_q <= ~cmd_data[0];
            end
            if (bp_hit_set) begin
                bp_hit_q <= 1'b1;
            end else if (bp_hit_clr) begin
                bp_hit_q <= 1'b0;
            end
        end
    end

    assign bp_match = bp_valid_q && (pc == bp_addr_q) && !bp_skip_q;
    assign bp_hit   = bp_hit_q;
`else
    assign bp_match = 1'b0;
    assign bp_hit   = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = &{1'b0, cmd_data, pc, bp_skip_q, bp_hit_set, bp_hit_clr, cmd_set_bp};

    assign halted  = halted_q;
    assign ret_cnt = ret_cnt_q;
    assign state   = state_q;
endmodule

// File: doc/sccpu_run_ctrl.md
# sccpu_run_ctrl

Run-control sequencer for the single-cycle CPU. It gates the core's state-update enable so the core can be halted, free-run, single- or N-stepped, and stopped on a PC breakpoint, and it counts retired instructions. It sits between the top-level `sccomp` and its PC, register-file and data-memory write enables, and is driven by a debug command port (switches/UART front-end or testbench).

## Interface
- `STEP_W`, default 16: width of the step-count field and step counter.
- `RESET_RUN`, default 1: 1 = enter RUN on reset release (free-run, as today); 0 = enter HALT.
- `clk` in 1: core clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command strobe; one command per asserted cycle.
- `cmd_op` in 2: 00 HALT, 01 RUN, 10 STEP, 11 SET_BP.
- `cmd_data` in 32: STEP count in [STEP_W-1:0]; SET_BP address in [31:2], clear flag in [0].
- `pc` in 32: current core PC (address of the instruction executing this cycle).
- `cpu_en` out 1: core update enable; PC, register-file and data-memory writes occur only when 1.
- `halted` out 1: 1 in HALT state.
- `bp_hit` out 1: sticky breakpoint-stop flag.
- `ret_cnt` out 32: retired-instruction count.
- `state` out 2: 00 HALT, 01 RUN, 10 STEP.

## Operation
- Three-state FSM: HALT, RUN, STEP. There is no ready signal; every command is consumed on the edge where `cmd_valid`=1.
- HALT: `cpu_en`=0. RUN cmd -> RUN. STEP cmd -> STEP with `step_left` = count (count 0 treated as 1). SET_BP accepted. HALT cmd is a no-op.
- RUN: `cpu_en` = !bp_match. HALT cmd -> HALT. bp_match -> HALT with `bp_hit` set. STEP cmd ignored. SET_BP accepted; the new breakpoint takes effect the next cycle.
- STEP: `cpu_en`=1. Each enabled cycle decrements `step_left`; at `step_left`=1 the FSM returns to HALT. HALT cmd -> HALT immediately. Breakpoints are ignored. RUN and STEP cmds are ignored.
- bp_match = bp_valid & (pc == bp_addr) & !bp_skip.
- SET_BP: bp_addr = {cmd_data[31:2],2'b00}, bp_valid = ~cmd_data[0].
- bp_skip is set on a HALT->RUN transition and cleared after the first RUN cycle, so resuming from a breakpoint executes the breakpointed instruction.
- `bp_hit` is cleared when a RUN or STEP cmd is accepted from HALT.
- `ret_cnt` increments in every cycle with `cpu_en`=1 and wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (async): state = RUN if RESET_RUN else HALT. bp_valid=0, bp_addr=0, bp_skip=0, step_left=0, bp_hit=0, ret_cnt=0, halted = !RESET_RUN.
- `cpu_en` is combinational from the registered state, bp_match and `pc`. All other outputs are registered.
- A command sampled at edge k changes state at edge k. `cpu_en` reflects the new state in cycle k+1.
- Breakpoint latency is zero: the instruction at bp_addr is never executed in RUN (`cpu_en`=0 that cycle). The FSM is in HALT after the following edge.
- In the same cycle, a HALT cmd and bp_match in RUN give HALT with `bp_hit`=1.
- In the same cycle, SET_BP and bp_match use the old breakpoint.
- STEP N gives exactly N cycles of `cpu_en`=1, then HALT. `ret_cnt` grows by exactly N.
- When `rstn` is asserted mid-STEP or mid-RUN, the step count and the breakpoint are lost.

## Configuration
- `SCCPU_RUN_CTRL_BP_EN` defined: breakpoint logic present as described.
- `SCCPU_RUN_CTRL_BP_EN` undefined:
  - bp registers are removed and bp_match is tied to 0.
  - SET_BP is a no-op and `bp_hit` is constant 0.
  - All other behaviour is unchanged.

## Test plan
- **Reset default:** RESET_RUN=1, release `rstn` -> `cpu_en`=1 from the first cycle, `state`=01, `ret_cnt` counts 1,2,3… per clock.
- **Step:** RESET_RUN=0; STEP with cmd_data=3 -> exactly 3 cycles of `cpu_en`=1, `ret_cnt`=3, `halted`=1. STEP with 0 -> 1 cycle, `ret_cnt`=4.
- **Breakpoint stop and resume:** SET_BP 0x00003010, then RUN -> `cpu_en`=0 in the cycle `pc`=0x00003010, `halted`=1, `bp_hit`=1. A second RUN executes 0x00003010 (`cpu_en`=1) and `bp_hit`=0.
- **Clear and collision:** SET_BP 0x00003011 (clear) -> no stop at 0x00003010. In RUN, a HALT cmd in the same cycle as bp_match -> HALT, `bp_hit`=1.
- **Wrap and async reset:** force `ret_cnt`=0xFFFFFFFF in RUN -> next value 0. Assert `rstn`=0 mid-STEP with step_left=5 -> outputs go immediately to reset values without a clock edge.
- **Macro off:** build without `SCCPU_RUN_CTRL_BP_EN`; SET_BP 0x00003010 then RUN -> no stop at 0x00003010, `bp_hit` stays 0.
